// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: default widths, reset PC and fetch FSM states.
package riscv_pkg;

    localparam int          WIDTH_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [DATA_W-1:0]         head,
    output logic                      head_vld,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop & head_vld;
    assign do_push  = push & ((count != CW'(DEPTH)) | do_pop);
    assign head     = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; the head is masked by the valid count instead.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC ownership, credit-limited imem requests, response buffering and redirect flush.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t        state;
    logic [WIDTH-1:0]    pc;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       discard_new;
    logic [WIDTH-1:0]    pcq_head;
    logic                pcq_vld;
    logic                req_fire;
    logic                rsp_eff;
    logic                keep;
    logic [2*WIDTH-1:0]  fifo_head;

    // Credit covers both in-flight requests and buffered instructions, so the FIFO cannot overflow.
    assign imem_req_valid = (state == ST_FETCH) &&
                            ((int'(outstanding) + int'(fifo_count)) < DEPTH);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_eff        = imem_rsp_valid & (pcq_vld | (discard != '0));
    assign keep           = rsp_eff & pcq_vld & (state == ST_FETCH) & ~redirect_valid;
    assign discard_new    = outstanding + discard + CW'(req_fire) - CW'(rsp_eff);

    // The PC queue depth doubles as the live outstanding-request count.
    sync_fifo #(.DATA_W(WIDTH), .DEPTH(DEPTH)) u_pcq (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (pc),
        .pop       (keep),
        .flush     (redirect_valid),
        .head      (pcq_head),
        .head_vld  (pcq_vld),
        .count     (outstanding)
    );

    sync_fifo #(.DATA_W(2*WIDTH), .DEPTH(DEPTH)) u_ififo (
        .clk       (clk),
        .reset     (reset),
        .push      (keep),
        .push_data ({imem_rsp_data, pcq_head}),
        .pop       (inst_valid & inst_ready),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .head_vld  (inst_valid),
        .count     (fifo_count)
    );

    assign inst    = fifo_head[2*WIDTH-1:WIDTH];
    assign inst_pc = fifo_head[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            if (req_fire) pc <= pc + WIDTH'(4);
            unique case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (redirect_valid) pc <= {redirect_pc[WIDTH-1:2], 2'b00};
                end
                ST_FETCH, ST_FLUSH: begin
                    if (redirect_valid) begin
                        pc      <= {redirect_pc[WIDTH-1:2], 2'b00};
                        discard <= discard_new;
                        state   <= (discard_new != '0) ? ST_FLUSH : ST_FETCH;
                    end else if (state == ST_FLUSH && rsp_eff) begin
                        discard <= discard - CW'(1);
                        if (discard == CW'(1)) state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a queue-based model of memory, credits and redirects.
module tb_instr_fetch;
    localparam int          W      = 32;
    localparam int          D      = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [W-1:0]  imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [W-1:0]  imem_rsp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [W-1:0]  inst;
    logic [W-1:0]  inst_pc;

    always #5 clk = ~clk;

    instr_fetch #(.WIDTH(W), .RESET_PC(RST_PC), .DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          live;
    } mreq_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } dent_t;

    mreq_t       mq[$];
    dent_t       dq[$];
    int          mode;
    logic [31:0] mpc;
    int          cyc;
    int          n_vec;
    int          n_err;
    int          p_ready, p_rsp, p_irdy, p_redir, p_stray, lat_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        dq.delete();
        mode = 0;
        mpc  = RST_PC;
    endfunction

    task automatic step();
        bit          exp_rv;
        bit          fire;
        bit          pop;
        bit          rsp;
        mreq_t       h;
        mreq_t       nr;
        dent_t       de;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        exp_rv = (mode == 1) && ((mq.size() + dq.size()) < D);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("imem_addr", imem_addr, mpc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, dq.size() != 0});
        if (dq.size() != 0) begin
            check("inst", inst, dq[0].data);
            check("inst_pc", inst_pc, dq[0].pc);
        end

        imem_req_ready = ($urandom_range(99) < p_ready);
        if (mq.size() != 0) begin
            rsp           = (mq[0].due <= cyc) && ($urandom_range(99) < p_rsp);
            imem_rsp_data = mq[0].data;
        end else begin
            rsp           = ($urandom_range(99) < p_stray);
            imem_rsp_data = $urandom();
        end
        imem_rsp_valid = rsp;
        redirect_valid = ($urandom_range(99) < p_redir);
        case ($urandom_range(3))
            0:       tgt = 32'h0000_0103;
            1:       tgt = 32'hFFFF_FFFC;
            default: tgt = $urandom();
        endcase
        redirect_pc = tgt;
        inst_ready  = ($urandom_range(99) < p_irdy);

        fire = exp_rv && imem_req_ready;
        pop  = (dq.size() != 0) && inst_ready;
        if (mode == 0) begin
            mode = 1;
            if (redirect_valid) mpc = tgt & ~32'd3;
        end else begin
            if (pop) void'(dq.pop_front());
            if (rsp && mq.size() != 0) begin
                h = mq.pop_front();
                if (h.live && !redirect_valid) begin
                    de.data = h.data;
                    de.pc   = h.addr;
                    dq.push_back(de);
                end
            end
            if (fire) begin
                nr.addr = mpc;
                nr.data = $urandom();
                nr.due  = cyc + int'($urandom_range(lat_max, 1));
                nr.live = 1'b1;
                mq.push_back(nr);
                mpc = mpc + 32'd4;
            end
            if (redirect_valid) begin
                mpc = tgt & ~32'd3;
                dq.delete();
                foreach (mq[i]) mq[i].live = 1'b0;
                mode = (mq.size() != 0) ? 2 : 1;
            end else if (mode == 2 && mq.size() == 0) begin
                mode = 1;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2 imem_rsp_valid = 1'b1;
            imem_rsp_data = $urandom();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic set_knobs(input int rdy, input int rs, input int ir, input int rd,
                             input int st, input int lm);
        p_ready = rdy; p_rsp = rs; p_irdy = ir; p_redir = rd; p_stray = st; lat_max = lm;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        model_reset();
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Streaming: latency 1, always ready, decoder always consuming.
        set_knobs(100, 100, 100, 0, 0, 1);
        repeat (100) step();
        // Decoder stalled: credits run out after DEPTH requests.
        set_knobs(100, 100, 0, 0, 0, 1);
        repeat (30) step();
        set_knobs(70, 80, 60, 5, 3, 4);
        repeat (2000) step();
        set_knobs(100, 100, 0, 0, 0, 2);
        repeat (20) step();
        mid_reset();
        set_knobs(80, 90, 70, 8, 10, 3);
        repeat (1500) step();
        set_knobs(100, 100, 100, 20, 0, 1);
        repeat (500) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
